// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands/op valid       in_ready   unit idle and not flushing
//   a, b       dividend (rs1), divisor (rs2)
//   op         funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   flush      abort any in-flight operation
//   out_valid  result valid            out_ready  consumer takes the result
//   out        quotient (op[1]=0) or remainder (op[1]=1)
//
// Optional feature macro: DIV_FAST_SPECIAL_EN
//   defined   - divide-by-zero and signed overflow skip CALC (2-edge latency)
//   undefined - every operation takes the full XLEN+2 latency

module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_t            state;
    state_t            state_n;
    logic [1:0]        op_r;
    logic              neg_q;
    logic              neg_r;
    logic              sp_div0;
    logic              sp_ovf;
    logic [XLEN-1:0]   a_orig;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN-1:0]   quo;
    logic [XLEN:0]     rem;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              signed_op;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              is_div0;
    logic              is_ovf;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic              q_bit;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   result;

    // The remainder never exceeds the divisor, so its top bit is only a
    // guard for the trial subtraction and is not otherwise consumed.
    logic              unused_rem_msb;
    assign unused_rem_msb = rem[XLEN];

    assign in_ready  = (state == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign signed_op = ~op[0];

    // Operand conditioning at accept time. |MIN_NEG| wraps to MIN_NEG,
    // which is still the correct magnitude when read as unsigned.
    always_comb begin
        abs_a   = (signed_op && a[XLEN-1]) ? (~a + 1'b1) : a;
        abs_b   = (signed_op && b[XLEN-1]) ? (~b + 1'b1) : b;
        is_div0 = (b == '0);
        is_ovf  = signed_op && (a == MIN_NEG) && (b == '1);
    end

    // One restoring step: the dividend is shifted out of quo MSB-first while
    // quotient bits are shifted in at the bottom.
    always_comb begin
        rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
        diff   = rem_sh - {1'b0, dvsr};
        q_bit  = ~diff[XLEN];
    end

    always_comb begin
        q_fix = neg_q ? (~quo + 1'b1) : quo;
        r_fix = neg_r ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
        if (sp_div0) begin
            q_fix = '1;
            r_fix = a_orig;
        end else if (sp_ovf) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
        result = op_r[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
                        state_n = (is_div0 || is_ovf) ? FIX : CALC;
`else
                        state_n = CALC;
`endif
                    end
                end
                CALC: begin
                    if (count == LAST_STEP) begin
                        state_n = FIX;
                    end
                end
                FIX: begin
                    state_n = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            sp_div0   <= 1'b0;
            sp_ovf    <= 1'b0;
            a_orig    <= '0;
            dvsr      <= '0;
            quo       <= '0;
            rem       <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                op_r    <= op;
                neg_q   <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                neg_r   <= signed_op && a[XLEN-1];
                sp_div0 <= is_div0;
                sp_ovf  <= is_ovf;
                a_orig  <= a;
                dvsr    <= abs_b;
                quo     <= abs_a;
                rem     <= '0;
                count   <= '0;
            end else if (state == CALC) begin
                rem   <= q_bit ? diff : rem_sh;
                quo   <= {quo[XLEN-2:0], q_bit};
                count <= count + 1'b1;
            end

            if (flush) begin
                out_valid <= 1'b0;
            end else if (state == FIX) begin
                out       <= result;
                out_valid <= 1'b1;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit
`timescale 1ns/1ps

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 34;
`endif
    localparam int LAT = 34;

    typedef struct {
        logic [31:0] val;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_ov = 1'b0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each rising out_valid and checks value
    // and latency (accept edge counted as edge 1); also checks that out
    // stays put while the consumer stalls.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", out, e.val);
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
                held = out;
            end else if (out_valid && prev_ov) begin
                check("out_stable", out, held);
            end
            prev_ov <= out_valid;
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                         input logic [31:0] ev, input int lat, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            in_valid = 1'b1;
            a  = ia;
            b  = ib;
            op = iop;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) begin
                e.val = ev;
                e.acc = cyc;
                e.lat = lat;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            check("result_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                       input logic [31:0] ev, input int lat);
        issue(ia, ib, iop, ev, lat, 1'b1);
        wait_idle();
    endtask

    initial begin
        int n;
        #1;
        check("reset_out", out, 32'h0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Normal operations
        run(32'd20,        32'd3,        2'b00, 32'd6,         LAT);
        run(32'd20,        32'd3,        2'b10, 32'd2,         LAT);
        run(32'hFFFFFFEC,  32'd3,        2'b00, 32'hFFFFFFFA,  LAT);
        run(32'hFFFFFFEC,  32'd3,        2'b10, 32'hFFFFFFFE,  LAT);
        run(32'hFFFFFFFF,  32'd2,        2'b11, 32'd1,         LAT);
        run(32'hFFFFFFFF,  32'd2,        2'b01, 32'h7FFFFFFF,  LAT);
        run(32'd100,       32'hFFFFFFF9, 2'b00, 32'hFFFFFFF2,  LAT);
        run(32'd100,       32'hFFFFFFF9, 2'b10, 32'd2,         LAT);

        // Divide by zero and signed overflow
        run(32'd7,         32'd0,        2'b00, 32'hFFFFFFFF,  LAT_SP);
        run(32'd7,         32'd0,        2'b10, 32'd7,         LAT_SP);
        run(32'h80000000,  32'd0,        2'b11, 32'h80000000,  LAT_SP);
        run(32'hFFFFFFF9,  32'd0,        2'b10, 32'hFFFFFFF9,  LAT_SP);
        run(32'h80000000,  32'hFFFFFFFF, 2'b00, 32'h80000000,  LAT_SP);
        run(32'h80000000,  32'hFFFFFFFF, 2'b10, 32'd0,         LAT_SP);
        run(32'h80000000,  32'hFFFFFFFF, 2'b01, 32'd0,         LAT);

        // Backpressure
        out_ready = 1'b0;
        issue(32'd45, 32'd7, 2'b01, 32'd6, LAT, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_held_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        run(32'd45, 32'd7, 2'b11, 32'd3, LAT);

        // Flush in the middle of CALC
        issue(32'd1000, 32'd9, 2'b00, 32'd0, LAT, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);
        check("flush_no_valid", {31'd0, out_valid}, 32'd0);
        run(32'd1000, 32'd9, 2'b00, 32'd111, LAT);

        // Asynchronous reset in the middle of an operation
        issue(32'd77, 32'd5, 2'b00, 32'd0, LAT, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out", out, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_valid", {31'd0, out_valid}, 32'd0);
        run(32'd77, 32'd5, 2'b10, 32'd2, LAT);
        run(32'd77, 32'd5, 2'b00, 32'd15, LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
